// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Purpose : shared definitions for the instruction fetch unit: FSM state
//           encoding, word size and the default reset PC.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_STALLED = 2'd1,
      ST_HALTED  = 2'd2
   } fetch_state_e;

   localparam int unsigned WORD_BYTES       = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Byte address of the last word in an instruction memory of mem_words words.
   function automatic logic [31:0] last_word_addr(input int unsigned mem_words);
      return 32'(WORD_BYTES * (mem_words - 1));
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_if
// Purpose : bundles the fetch unit's control inputs, instruction memory
//           port and IF/ID outputs.
// Signals : stall, branch_taken, branch_target[31:0], jump, jump_index[25:0],
//           imem_instruction[31:0]  -> into the fetch unit
//           imem_addr[31:0], if_id_instr[31:0], if_id_pc4[31:0],
//           if_id_valid, halted     -> out of the fetch unit
// Modports: master = fetch unit side, slave = pipeline/memory side.
// ---------------------------------------------------------------------------
interface fetch_if;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] imem_instruction;
   logic [31:0] imem_addr;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;

   modport master (
      input  stall, branch_taken, branch_target, jump, jump_index,
             imem_instruction,
      output imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted
   );

   modport slave (
      output stall, branch_taken, branch_target, jump, jump_index,
             imem_instruction,
      input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, halted
   );
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// ---------------------------------------------------------------------------
// next_pc_sel
// Purpose : combinational redirect detection and target computation.
//           Jump has priority over a taken branch.
// Ports   : jump_i, branch_taken_i   redirect requests
//           branch_target_i[31:0]    branch byte address (low 2 bits dropped)
//           jump_index_i[25:0]       J-type index field
//           if_id_pc4_i[31:0]        pc+4 of the instruction in IF/ID
//           redirect_o               a redirect happens this edge
//           target_o[31:0]           word-aligned redirect address
// ---------------------------------------------------------------------------
module next_pc_sel (
   input  logic        jump_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic [25:0] jump_index_i,
   input  logic [31:0] if_id_pc4_i,
   output logic        redirect_o,
   output logic [31:0] target_o
);

   always_comb begin
      redirect_o = jump_i | branch_taken_i;
      if (jump_i) begin
         // Region bits come from pc+4 of the jump itself.
         target_o = (if_id_pc4_i & 32'hF000_0000) | {4'b0000, jump_index_i, 2'b00};
      end else begin
         target_o = branch_target_i & 32'hFFFF_FFFC;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Purpose : instruction fetch stage in front of a registered (1-cycle)
//           instruction memory. Produces IF/ID instruction, pc+4 and valid,
//           handles stall, branch/jump redirects and halts at the end of
//           instruction memory instead of wrapping.
// Ports   : clk    clock, rising edge
//           reset  asynchronous, active-high
//           bus    fetch_if.master (see fetch_unit_if.sv)
// Params  : RESET_PC  byte address loaded on reset
//           MEM_WORDS instruction memory depth in 32-bit words
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int unsigned MEM_WORDS = 128
) (
   input  logic     clk,
   input  logic     reset,
   fetch_if.master  bus
);

   localparam logic [31:0] LAST_PC = last_word_addr(MEM_WORDS);
   localparam logic [31:0] STEP    = 32'(WORD_BYTES);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  resp_pc_q, resp_pc_d;      // address the memory sampled last edge
   logic         resp_valid_q, resp_valid_d;
   logic [31:0]  hold_instr_q, hold_instr_d;

   logic         redirect;
   logic [31:0]  redirect_target;
   logic [31:0]  if_id_pc4;
   logic         advance;

   assign if_id_pc4 = resp_pc_q + STEP;

   next_pc_sel u_next_pc_sel (
      .jump_i          (bus.jump),
      .branch_taken_i  (bus.branch_taken),
      .branch_target_i (bus.branch_target),
      .jump_index_i    (bus.jump_index),
      .if_id_pc4_i     (if_id_pc4),
      .redirect_o      (redirect),
      .target_o        (redirect_target)
   );

   // Outputs
   assign bus.imem_addr   = pc_q;
   assign bus.if_id_instr = (state_q == ST_STALLED) ? hold_instr_q : bus.imem_instruction;
   assign bus.if_id_pc4   = if_id_pc4;
   assign bus.if_id_valid = resp_valid_q;
   assign bus.halted      = (state_q == ST_HALTED);

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      resp_pc_d    = resp_pc_q;
      resp_valid_d = resp_valid_q;
      hold_instr_d = hold_instr_q;
      advance      = 1'b0;

      if (redirect) begin
         pc_d         = redirect_target;
         resp_valid_d = 1'b0;
         state_d      = ST_FETCH;
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               if (!bus.stall) begin
                  advance = 1'b1;
               end else if (resp_valid_q) begin
                  // Memory will move on to pc next edge, so keep the word
                  // currently shown. With nothing valid, stall only holds pc.
                  hold_instr_d = bus.imem_instruction;
                  state_d      = ST_STALLED;
               end
            end
            ST_STALLED: begin
               advance = !bus.stall;
            end
            ST_HALTED: begin
               // While stalled the memory keeps re-reading the held pc, so
               // the shown word stays correct without a hold register.
               if (!bus.stall) begin
                  resp_valid_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_FETCH;
            end
         endcase

         if (advance) begin
            if (pc_q <= LAST_PC) begin
               resp_pc_d    = pc_q;
               resp_valid_d = 1'b1;
               if (pc_q == LAST_PC) begin
                  state_d = ST_HALTED;
               end else begin
                  pc_d    = pc_q + STEP;
                  state_d = ST_FETCH;
               end
            end else begin
               // Redirected beyond memory: nothing to deliver.
               resp_valid_d = 1'b0;
               state_d      = ST_HALTED;
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         resp_pc_q    <= 32'h0;
         resp_valid_q <= 1'b0;
         hold_instr_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         resp_pc_q    <= resp_pc_d;
         resp_valid_q <= resp_valid_d;
         hold_instr_q <= hold_instr_d;
      end
   end

endmodule
